// File: rtl/image_ram_arbiter.sv
// Round-robin, burst-capable owner arbiter that shares one single-port image RAM
// between the BMP loader (0), the processing engine (1) and the writeback unit (2).
module image_ram_arbiter #(
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 20,
   parameter int MAX_BURST  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              req,
   input  logic [2:0]              wen,
   input  logic [3*ADDR_WIDTH-1:0] addr,
   input  logic [3*BYTE_WIDTH-1:0] wdata,
   output logic [2:0]              gnt,
   output logic [2:0]              rvalid,
   output logic [BYTE_WIDTH-1:0]   rdata,
   output logic                    RAM_ren,
   output logic                    RAM_wen,
   output logic [ADDR_WIDTH-1:0]   RAM_addr,
   output logic [BYTE_WIDTH-1:0]   RAM_in,
   input  logic [BYTE_WIDTH-1:0]   RAM_out,
   output logic                    busy,
   output logic [1:0]              owner
);
   localparam int               NUM_REQ  = 3;
   localparam int               CNT_W    = $clog2(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST - 1);
   localparam logic [1:0]       NO_OWNER = 2'd3;

   typedef enum logic {IDLE, OWN} state_t;

   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
   logic [NUM_REQ-1:0][BYTE_WIDTH-1:0] wdata_a;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[i] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
   end

   state_t             state_q, state_d;
   logic [1:0]         owner_q, owner_d;
   logic [1:0]         last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

   logic [NUM_REQ-1:0] cand;
   logic [1:0]         start;
   logic [2:0]         idx;
   logic               win_vld;
   logic [1:0]         win;
   logic               access;

   // The current owner never competes against itself, so a release and a
   // preemption share the same search starting just past last_owner.
   always_comb begin
      cand = req;
      if (state_q == OWN) cand[owner_q] = 1'b0;
      start   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      win_vld = 1'b0;
      win     = 2'd0;
      idx     = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, start} + 3'(k);
         if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
         if (!win_vld && cand[idx[1:0]]) begin
            win_vld = 1'b1;
            win     = idx[1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = OWN;
               owner_d = win;
               last_d  = win;
               cnt_d   = '0;
            end
         end
         OWN: begin
            if (req[owner_q]) begin
               access = 1'b1;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (win_vld) begin
                  owner_d = win;
                  last_d  = win;
                  cnt_d   = '0;
               end
            end else if (win_vld) begin
               owner_d = win;
               last_d  = win;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               owner_d = NO_OWNER;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = NO_OWNER;
            cnt_d   = '0;
         end
      endcase
      gnt_d = '0;
      if (state_d == OWN) gnt_d[owner_d] = 1'b1;
   end

   // Read returns are tagged with the issuing owner so they route correctly
   // even when ownership changes on the same edge.
   always_comb begin
      RAM_ren  = 1'b0;
      RAM_wen  = 1'b0;
      RAM_addr = '0;
      RAM_in   = '0;
      rvalid_d = '0;
      if (state_q == OWN) begin
         RAM_addr = addr_a[owner_q];
         RAM_in   = wdata_a[owner_q];
         RAM_ren  = access & ~wen[owner_q];
         RAM_wen  = access & wen[owner_q];
      end
      if (RAM_ren) rvalid_d[owner_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= NO_OWNER;
         last_q   <= 2'd2;
         cnt_q    <= '0;
         gnt_q    <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign gnt    = gnt_q;
   assign rvalid = rvalid_q;
   assign rdata  = RAM_out;
   assign busy   = (state_q == OWN);
   assign owner  = owner_q;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Scoreboard bench for image_ram_arbiter: stimulus pushes expected RAM accesses
// and read returns; a negedge monitor pops and compares them.
module tb_image_ram_arbiter;
   localparam int BW = 8;
   localparam int AW = 20;
   localparam int MB = 4;

   logic          clk, rst;
   logic [2:0]    req, wen;
   logic [3*AW-1:0] addr;
   logic [3*BW-1:0] wdata;
   logic [2:0]    gnt, rvalid;
   logic [BW-1:0] rdata;
   logic          RAM_ren, RAM_wen;
   logic [AW-1:0] RAM_addr;
   logic [BW-1:0] RAM_in, RAM_out;
   logic          busy;
   logic [1:0]    owner;

   image_ram_arbiter #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .RAM_ren(RAM_ren), .RAM_wen(RAM_wen),
      .RAM_addr(RAM_addr), .RAM_in(RAM_in), .RAM_out(RAM_out), .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model, initial contents mem[i] = 3*i+1
   logic [BW-1:0] mem [256];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(3*i + 1);
      RAM_out = '0;
   end
   always @(posedge clk) begin
      if (RAM_wen) mem[RAM_addr[7:0]] <= RAM_in;
      if (RAM_ren) RAM_out <= mem[RAM_addr[7:0]];
   end

   typedef struct packed {
      logic [1:0]    own;
      logic          wr;
      logic [AW-1:0] a;
      logic [BW-1:0] d;
   } acc_t;
   typedef struct packed {
      logic [1:0]    who;
      logic [BW-1:0] d;
   } rd_t;

   acc_t acc_q[$];
   rd_t  rd_q[$];
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic exp_acc(input int o, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
      acc_t e;
      e.own = 2'(o); e.wr = w; e.a = a; e.d = d;
      acc_q.push_back(e);
   endtask

   task automatic exp_rd(input int o, input logic [BW-1:0] d);
      rd_t e;
      e.who = 2'(o); e.d = d;
      rd_q.push_back(e);
   endtask

   task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
      wen[i] = w;
      addr[i*AW +: AW] = a;
      wdata[i*BW +: BW] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_gnt"},     32'(gnt), 32'd0);
      chk({tag, "_rvalid"},  32'(rvalid), 32'd0);
      chk({tag, "_ren"},     32'(RAM_ren), 32'd0);
      chk({tag, "_wen"},     32'(RAM_wen), 32'd0);
      chk({tag, "_addr"},    32'(RAM_addr), 32'd0);
      chk({tag, "_in"},      32'(RAM_in), 32'd0);
      chk({tag, "_busy"},    32'(busy), 32'd0);
      chk({tag, "_owner"},   32'(owner), 32'd3);
   endtask

   // Monitor: compares every RAM access and every read return against the queues.
   always @(negedge clk) begin
      if (RAM_ren || RAM_wen) begin
         chk("ren_wen_exclusive", 32'(RAM_ren & RAM_wen), 32'd0);
         if (acc_q.size() == 0) begin
            chk("unexpected_access", 32'(RAM_addr), 32'hFFFF_FFFF);
         end else begin
            acc_t e;
            e = acc_q.pop_front();
            chk("acc_owner", 32'(owner), 32'(e.own));
            chk("acc_gnt",   32'(gnt), 32'(3'b001 << e.own));
            chk("acc_type",  32'(RAM_wen), 32'(e.wr));
            chk("acc_addr",  32'(RAM_addr), 32'(e.a));
            if (e.wr) chk("acc_wdata", 32'(RAM_in), 32'(e.d));
         end
      end
      if (rvalid != 3'b000) begin
         if (rd_q.size() == 0) begin
            chk("unexpected_rvalid", 32'(rvalid), 32'd0);
         end else begin
            rd_t r;
            r = rd_q.pop_front();
            chk("rvalid_route", 32'(rvalid), 32'(3'b001 << r.who));
            chk("rdata", 32'(rdata), 32'(r.d));
         end
      end
   end

   initial begin
      rst = 1'b1; req = '0; wen = '0; addr = '0; wdata = '0;
      #1;
      chk_reset("init");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Single requester: three reads of addr 0,1,2
      req = 3'b001; set_port(0, 1'b0, 20'd0, 8'h00);
      chk("single_gnt_before", 32'(gnt), 32'd0);
      step(); chk("single_gnt_rise", 32'(gnt), 32'b001); chk("single_busy", 32'(busy), 32'd1);
      exp_acc(0, 1'b0, 20'd0, 8'h00); exp_rd(0, 8'd1);
      step(); set_port(0, 1'b0, 20'd1, 8'h00); exp_acc(0, 1'b0, 20'd1, 8'h00); exp_rd(0, 8'd4);
      step(); set_port(0, 1'b0, 20'd2, 8'h00); exp_acc(0, 1'b0, 20'd2, 8'h00); exp_rd(0, 8'd7);
      step(); req = 3'b000;
      step(); chk("single_idle_gnt", 32'(gnt), 32'd0);
      chk("single_idle_owner", 32'(owner), 32'd3); chk("single_idle_busy", 32'(busy), 32'd0);

      // Simultaneous requests after reset: order 0,1,2 with zero-gap handoffs
      rst = 1'b1; step(); rst = 1'b0;
      set_port(0, 1'b0, 20'd10, 8'h00); set_port(1, 1'b0, 20'd11, 8'h00); set_port(2, 1'b0, 20'd12, 8'h00);
      req = 3'b111;
      step(); chk("rr_gnt0", 32'(gnt), 32'b001); exp_acc(0, 1'b0, 20'd10, 8'h00); exp_rd(0, 8'd31);
      step(); req = 3'b110; chk("rr_gnt0_release", 32'(gnt), 32'b001);
      step(); chk("rr_gnt1", 32'(gnt), 32'b010); exp_acc(1, 1'b0, 20'd11, 8'h00); exp_rd(1, 8'd34);
      step(); req = 3'b100; chk("rr_gnt1_release", 32'(gnt), 32'b010);
      step(); chk("rr_gnt2", 32'(gnt), 32'b100); exp_acc(2, 1'b0, 20'd12, 8'h00); exp_rd(2, 8'd37);
      step(); req = 3'b000;
      step(); chk("rr_idle", 32'(gnt), 32'd0);

      // Preemption: requester 1 streams writes, requester 2 joins
      req = 3'b010; set_port(1, 1'b1, 20'd100, 8'h50);
      step(); chk("pre_gnt1", 32'(gnt), 32'b010); exp_acc(1, 1'b1, 20'd100, 8'h50);
      step(); set_port(1, 1'b1, 20'd101, 8'h51); set_port(2, 1'b0, 20'd100, 8'h00); req = 3'b110;
      exp_acc(1, 1'b1, 20'd101, 8'h51);
      step(); set_port(1, 1'b1, 20'd102, 8'h52); exp_acc(1, 1'b1, 20'd102, 8'h52);
      step(); set_port(1, 1'b1, 20'd103, 8'h53); exp_acc(1, 1'b1, 20'd103, 8'h53);
      chk("pre_still_gnt1", 32'(gnt), 32'b010);
      step(); chk("pre_gnt2", 32'(gnt), 32'b100); set_port(1, 1'b1, 20'd104, 8'h54);
      exp_acc(2, 1'b0, 20'd100, 8'h00); exp_rd(2, 8'h50);
      step(); req = 3'b010; chk("pre_gnt2_release", 32'(gnt), 32'b100);
      step(); chk("pre_regain1", 32'(gnt), 32'b010); exp_acc(1, 1'b1, 20'd104, 8'h54);
      step(); req = 3'b000;
      step(); chk("pre_idle", 32'(gnt), 32'd0);

      // Handoff read routing: 0 reads 2..5 (5 in its last cycle), 1 reads 9 next
      req = 3'b011; set_port(0, 1'b0, 20'd2, 8'h00); set_port(1, 1'b0, 20'd9, 8'h00);
      step(); chk("ho_gnt0", 32'(gnt), 32'b001); exp_acc(0, 1'b0, 20'd2, 8'h00); exp_rd(0, 8'd7);
      step(); set_port(0, 1'b0, 20'd3, 8'h00); exp_acc(0, 1'b0, 20'd3, 8'h00); exp_rd(0, 8'd10);
      step(); set_port(0, 1'b0, 20'd4, 8'h00); exp_acc(0, 1'b0, 20'd4, 8'h00); exp_rd(0, 8'd13);
      step(); set_port(0, 1'b0, 20'd5, 8'h00); exp_acc(0, 1'b0, 20'd5, 8'h00); exp_rd(0, 8'd16);
      step(); chk("ho_gnt1", 32'(gnt), 32'b010); exp_acc(1, 1'b0, 20'd9, 8'h00); exp_rd(1, 8'd28);
      req = 3'b010;
      step(); req = 3'b000;
      step(); chk("ho_idle", 32'(gnt), 32'd0);

      // Lone owner for 200 cycles, then a competitor preempts immediately
      req = 3'b100; set_port(2, 1'b1, 20'd150, 8'h00);
      step();
      for (int k = 0; k < 200; k++) begin
         set_port(2, 1'b1, 20'd150, 8'(k));
         chk("lone_gnt_held", 32'(gnt), 32'b100);
         exp_acc(2, 1'b1, 20'd150, 8'(k));
         step();
      end
      req = 3'b101; set_port(0, 1'b0, 20'd0, 8'h00); set_port(2, 1'b1, 20'd150, 8'hC8);
      exp_acc(2, 1'b1, 20'd150, 8'hC8);
      step(); chk("lone_saturated_preempt", 32'(gnt), 32'b001);
      exp_acc(0, 1'b0, 20'd0, 8'h00); exp_rd(0, 8'd1);
      step(); req = 3'b000;
      step(); chk("lone_idle", 32'(gnt), 32'd0);

      // Reset mid-burst with a read outstanding
      req = 3'b010; set_port(1, 1'b0, 20'd7, 8'h00);
      step(); chk("rst_gnt1", 32'(gnt), 32'b010); exp_acc(1, 1'b0, 20'd7, 8'h00);
      @(negedge clk);
      #1 rst = 1'b1; req = 3'b000;
      #1 chk_reset("midrst");
      step(); rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_no_rvalid", 32'(rvalid), 32'd0);
         chk("rst_owner_idle", 32'(owner), 32'd3);
      end

      chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
      chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
